// File: rtl/dqs_preamble_detect.sv
// dqs_preamble_detect: finds the DQS read preamble in deserialized 4-sample
// words, reports the edge phase and latency, and checks the burst toggles and
// the postamble.
//   clk          ISERDES divided clock (rising edge)
//   rst          asynchronous active-high reset
//   rd_start     arms detection for one read burst
//   dqs_samples  deserialized DQS word, bit 0 earliest
//   busy         FSM not idle
//   done         burst checked clean (pulse); phase/lat updated with it
//   phase        index of first rising edge within its word
//   lat          WAIT words preceding the edge word
//   err_*        one-cycle error pulses (preamble, glitch, timeout, overlap)
module dqs_preamble_detect #(
    parameter int unsigned PREAMBLE_LOW = 2,
    parameter int unsigned BURST_WORDS  = 2,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_start,
    input  logic [3:0] dqs_samples,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase,
    output logic [7:0] lat,
    output logic       err_preamble,
    output logic       err_glitch,
    output logic       err_timeout,
    output logic       err_overlap
);

    localparam int unsigned ZR_W  = $clog2(PREAMBLE_LOW + 2);
    localparam int unsigned REM_W = 6;
    localparam int unsigned LAT_W = 8;

    localparam logic [ZR_W-1:0]  ZR_MAX  = ZR_W'(PREAMBLE_LOW);
    localparam logic [REM_W-1:0] TOTAL   = REM_W'(4 * BURST_WORDS);
    localparam logic [LAT_W-1:0] TO_LAST = LAT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ZR_W-1:0]    zero_run_q, zero_run_d;
    logic               prev_q, prev_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               tog_q, tog_d;
    logic [1:0]         edge_phase_q, edge_phase_d;
    logic [LAT_W-1:0]   edge_lat_q, edge_lat_d;
    logic               ovl_pend_q, ovl_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         phase_q, phase_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               err_preamble_q, err_preamble_d;
    logic               err_glitch_q, err_glitch_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_overlap_q, err_overlap_d;

    logic               scan_prev;
    logic [ZR_W-1:0]    scan_zr;
    logic               edge_found;
    logic               edge_ok;
    logic [1:0]         edge_p;
    logic [3:0]         edge_exp;
    logic [3:0]         edge_mask;
    logic               edge_clean;
    logic [REM_W-1:0]   edge_rem;
    logic [3:0]         burst_exp;
    logic               burst_clean;
    logic               result_pulse;

    // Word scan: first 0->1 edge, its preamble qualification, and the
    // expected toggle patterns for the edge word and a burst word.
    always_comb begin
        scan_prev  = prev_q;
        scan_zr    = zero_run_q;
        edge_found = 1'b0;
        edge_ok    = 1'b0;
        edge_p     = 2'd0;
        edge_exp   = 4'b0;
        edge_mask  = 4'b0;
        burst_exp  = 4'b0;

        for (int i = 0; i < 4; i++) begin
            if (!edge_found) begin
                if (dqs_samples[i]) begin
                    if (!scan_prev) begin
                        edge_found = 1'b1;
                        edge_p     = 2'(i);
                        edge_ok    = (scan_zr >= ZR_MAX);
                    end
                    scan_zr = '0;
                end else if (scan_zr < ZR_MAX) begin
                    scan_zr = scan_zr + 1'b1;
                end
                scan_prev = dqs_samples[i];
            end
        end

        // Toggle pattern starts high at the edge index and alternates.
        for (int i = 0; i < 4; i++) begin
            edge_mask[i] = (i >= int'(edge_p));
            edge_exp[i]  = (i[0] == edge_p[0]);
            // Samples past the last toggle are postamble and must be low.
            burst_exp[i] = (REM_W'(i) < rem_q) ? (tog_q ^ i[0]) : 1'b0;
        end

        edge_clean  = (((dqs_samples ^ edge_exp) & edge_mask) == 4'b0);
        edge_rem    = TOTAL - REM_W'(4 - int'(edge_p));
        burst_clean = (dqs_samples == burst_exp);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        zero_run_d     = zero_run_q;
        prev_d         = prev_q;
        rem_d          = rem_q;
        tog_d          = tog_q;
        edge_phase_d   = edge_phase_q;
        edge_lat_d     = edge_lat_q;
        ovl_pend_d     = 1'b0;
        done_d         = 1'b0;
        phase_d        = phase_q;
        lat_d          = lat_q;
        err_preamble_d = 1'b0;
        err_glitch_d   = 1'b0;
        err_timeout_d  = 1'b0;
        err_overlap_d  = ovl_pend_q;

        unique case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                    zero_run_d = '0;
                    prev_d     = 1'b1;
                end
            end
            S_WAIT: begin
                if (edge_found) begin
                    if (!edge_ok) begin
                        err_preamble_d = 1'b1;
                        state_d        = S_IDLE;
                    end else if (!edge_clean) begin
                        err_glitch_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (edge_rem == '0) begin
                        done_d  = 1'b1;
                        phase_d = edge_p;
                        lat_d   = wait_cnt_q;
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_BURST;
                        rem_d        = edge_rem;
                        // 4-p samples consumed: next toggle is high when p is even.
                        tog_d        = ~edge_p[0];
                        edge_phase_d = edge_p;
                        edge_lat_d   = wait_cnt_q;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    zero_run_d = scan_zr;
                    prev_d     = scan_prev;
                end
            end
            S_BURST: begin
                if (!burst_clean) begin
                    err_glitch_d = 1'b1;
                    state_d      = S_IDLE;
                end else if (rem_q <= REM_W'(4)) begin
                    done_d  = 1'b1;
                    phase_d = edge_phase_q;
                    lat_d   = edge_lat_q;
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_q - REM_W'(4);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Overlap colliding with a result pulse is deferred one cycle so the
        // pulses stay mutually exclusive; the FSM is idle by then.
        result_pulse = done_d | err_preamble_d | err_glitch_d | err_timeout_d;
        if (rd_start && (state_q != S_IDLE)) begin
            if (result_pulse) begin
                ovl_pend_d = 1'b1;
            end else begin
                err_overlap_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= '0;
            zero_run_q     <= '0;
            prev_q         <= 1'b0;
            rem_q          <= '0;
            tog_q          <= 1'b0;
            edge_phase_q   <= '0;
            edge_lat_q     <= '0;
            ovl_pend_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            phase_q        <= '0;
            lat_q          <= '0;
            err_preamble_q <= 1'b0;
            err_glitch_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overlap_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            zero_run_q     <= zero_run_d;
            prev_q         <= prev_d;
            rem_q          <= rem_d;
            tog_q          <= tog_d;
            edge_phase_q   <= edge_phase_d;
            edge_lat_q     <= edge_lat_d;
            ovl_pend_q     <= ovl_pend_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            phase_q        <= phase_d;
            lat_q          <= lat_d;
            err_preamble_q <= err_preamble_d;
            err_glitch_q   <= err_glitch_d;
            err_timeout_q  <= err_timeout_d;
            err_overlap_q  <= err_overlap_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign phase        = phase_q;
    assign lat          = lat_q;
    assign err_preamble = err_preamble_q;
    assign err_glitch   = err_glitch_q;
    assign err_timeout  = err_timeout_q;
    assign err_overlap  = err_overlap_q;

endmodule

// File: tb/tb_dqs_preamble_detect.sv
// Directed testbench for dqs_preamble_detect (PREAMBLE_LOW=2, BURST_WORDS=2,
// TIMEOUT=16). Words are named s0s1s2s3; s0 is bit 0 of dqs_samples.
module tb_dqs_preamble_detect;

    logic       clk;
    logic       rst;
    logic       rd_start;
    logic [3:0] dqs_samples;
    logic       busy;
    logic       done;
    logic [1:0] phase;
    logic [7:0] lat;
    logic       err_preamble;
    logic       err_glitch;
    logic       err_timeout;
    logic       err_overlap;

    int nvec;
    int nerr;

    localparam logic [3:0] W0000 = 4'b0000;
    localparam logic [3:0] W1111 = 4'b1111;
    localparam logic [3:0] W1010 = 4'b0101;
    localparam logic [3:0] W0010 = 4'b0100;
    localparam logic [3:0] W1000 = 4'b0001;
    localparam logic [3:0] W1110 = 4'b0111;
    localparam logic [3:0] W1011 = 4'b1101;

    dqs_preamble_detect #(
        .PREAMBLE_LOW (2),
        .BURST_WORDS  (2),
        .TIMEOUT      (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_start     (rd_start),
        .dqs_samples  (dqs_samples),
        .busy         (busy),
        .done         (done),
        .phase        (phase),
        .lat          (lat),
        .err_preamble (err_preamble),
        .err_glitch   (err_glitch),
        .err_timeout  (err_timeout),
        .err_overlap  (err_overlap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector {busy,done,phase,lat,ep,eg,et,eo}.
    function automatic logic [15:0] ev(input logic b, input logic d,
                                       input logic [1:0] ph, input logic [7:0] lt,
                                       input logic ep, input logic eg,
                                       input logic et, input logic eo);
        return {b, d, ph, lt, ep, eg, et, eo};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {busy, done, phase, lat, err_preamble, err_glitch, err_timeout, err_overlap};
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word for one cycle; return #1 after the sampling edge.
    task automatic step(input logic rd, input logic [3:0] w);
        rd_start    = rd;
        dqs_samples = w;
        @(posedge clk);
        #1;
        rd_start    = 1'b0;
    endtask

    initial begin
        nvec        = 0;
        nerr        = 0;
        rst         = 1'b1;
        rd_start    = 1'b0;
        dqs_samples = W0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", ev(0, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        rst = 1'b0;
        step(0, W1010);
        check("idle_ignores_samples", ev(0, 0, 2'd0, 8'd0, 0, 0, 0, 0));

        // Clean burst, phase 0, two WAIT words before the edge.
        step(1, W0000);
        check("s1_arm", ev(1, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(0, W1111);
        check("s1_w1", ev(1, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(0, W0000);
        check("s1_w2", ev(1, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(0, W1010);
        check("s1_edge", ev(1, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(0, W1010);
        check("s1_done", ev(0, 1, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W0000);
        check("s1_after", ev(0, 0, 2'd0, 8'd2, 0, 0, 0, 0));

        // Phase 2 edge with postamble in the last word.
        step(1, W0000);
        check("s2_arm", ev(1, 0, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W0000);
        check("s2_w1", ev(1, 0, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W0010);
        check("s2_edge", ev(1, 0, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W1010);
        check("s2_b1", ev(1, 0, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W1000);
        check("s2_done", ev(0, 1, 2'd2, 8'd1, 0, 0, 0, 0));

        // Burst glitch: done never fires, phase/lat hold.
        step(1, W0000);
        check("s3_arm", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W0000);
        check("s3_w1", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W1010);
        check("s3_edge", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W1110);
        check("s3_glitch", ev(0, 0, 2'd2, 8'd1, 0, 1, 0, 0));
        step(0, W1010);
        check("s3_idle", ev(0, 0, 2'd2, 8'd1, 0, 0, 0, 0));

        // Timeout after sixteen all-low words.
        step(1, W0000);
        check("s4_arm", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        for (int k = 1; k <= 16; k++) begin
            step(0, W0000);
            if (k < 16) begin
                check($sformatf("s4_wait%0d", k), ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
            end else begin
                check("s4_timeout", ev(0, 0, 2'd2, 8'd1, 0, 0, 1, 0));
            end
        end

        // Preamble too short: a single low sample before the edge.
        step(1, W0000);
        check("s5_arm", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W1111);
        check("s5_w1", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W1011);
        check("s5_preamble", ev(0, 0, 2'd2, 8'd1, 1, 0, 0, 0));

        // rd_start while busy, in WAIT and again on the deciding BURST word.
        step(1, W0000);
        check("s6_arm", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(1, W1111);
        check("s6_ovl_wait", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 1));
        step(0, W0000);
        check("s6_w2", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(0, W1010);
        check("s6_edge", ev(1, 0, 2'd2, 8'd1, 0, 0, 0, 0));
        step(1, W1010);
        check("s6_done", ev(0, 1, 2'd0, 8'd2, 0, 0, 0, 0));
        step(0, W0000);
        check("s6_ovl_burst", ev(0, 0, 2'd0, 8'd2, 0, 0, 0, 1));
        step(0, W0000);
        check("s6_idle", ev(0, 0, 2'd0, 8'd2, 0, 0, 0, 0));

        // Asynchronous reset in the middle of a burst.
        step(1, W0000);
        step(0, W1111);
        step(0, W0000);
        step(0, W1010);
        check("s7_in_burst", ev(1, 0, 2'd0, 8'd2, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        check("s7_async_reset", ev(0, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, W1010);
        check("s7_post_reset_idle", ev(0, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(1, W0000);
        step(0, W0000);
        step(0, W0010);
        step(0, W1010);
        check("s7_burst", ev(1, 0, 2'd0, 8'd0, 0, 0, 0, 0));
        step(0, W1000);
        check("s7_done", ev(0, 1, 2'd2, 8'd1, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dqs_preamble_detect.md
DQS_PREAMBLE_DETECT -- requirements
Module: dqs_preamble_detect

Interface
REQ-001 SHALL have parameter PREAMBLE_LOW, default 2: minimum number of consecutive low DQS samples required before the first rising edge.
REQ-002 SHALL have parameter BURST_WORDS, default 2: burst length in 4-sample words, so the burst carries 4*BURST_WORDS DQS toggles; legal range 1..8.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum number of WAIT words searched for a preamble; legal range 1..255.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 port list:
- clk  in  1  ISERDES divided clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_start  in  1  single-cycle pulse that arms detection for one read burst.
- dqs_samples  in  4  deserialized DQS word; bit 0 is the earliest sample.
- busy  out  1  high while not in IDLE.
- done  out  1  one-cycle pulse when a burst checks clean.
- phase  out  2  index of the first rising edge within its word; valid with done.
- lat  out  8  number of WAIT words before the edge word; valid with done.
- err_preamble  out  1  one-cycle pulse: preamble too short.
- err_glitch  out  1  one-cycle pulse: burst or postamble mismatch.
- err_timeout  out  1  one-cycle pulse: no edge within TIMEOUT words.
- err_overlap  out  1  one-cycle pulse: rd_start received while busy.

Function
REQ-006 SHALL implement an FSM with states IDLE, WAIT and BURST.
REQ-007 IDLE: rd_start SHALL move the FSM to WAIT and clear the WAIT-word counter and zero_run; the stored previous sample SHALL be set to 1.
REQ-008 WAIT: the FSM SHALL scan samples 0..3 in order, using the stored previous sample (the last sample of the prior word) as the predecessor of sample 0.
REQ-009 WAIT: zero_run SHALL increment (saturating at PREAMBLE_LOW) on each 0 and clear on each 1; a 1 preceded by a 1 SHALL NOT count as an edge.
REQ-010 WAIT: the first 0->1 transition at index p SHALL be taken as the edge.
- If zero_run >= PREAMBLE_LOW: go to BURST, latch phase=p and lat=WAIT-word count, and set remaining toggles = 4*BURST_WORDS-(4-p).
- Otherwise: pulse err_preamble and go to IDLE.
REQ-011 WAIT: if TIMEOUT words have been evaluated with no edge, the FSM SHALL pulse err_timeout and go to IDLE; an edge found in the TIMEOUT-th word SHALL take precedence over the timeout.
REQ-012 The edge word SHALL match 1,0,1,0 from index p through index 3, otherwise err_glitch is raised.
REQ-013 BURST: each word SHALL match the continuing toggle pattern for the samples still remaining.
- Samples after the last toggle in the final word (the postamble) SHALL be 0.
- Any mismatch SHALL pulse err_glitch and return the FSM to IDLE.
REQ-014 BURST: when the last toggle is consumed cleanly, the FSM SHALL pulse done and go to IDLE.
- With p=0 and BURST_WORDS=1, done SHALL be decided from the edge word itself.
REQ-015 All outputs SHALL be registered; each pulse SHALL assert in the cycle after the deciding word is sampled.
REQ-016 rd_start while busy SHALL pulse err_overlap and be otherwise ignored; the current burst SHALL continue unaffected.
REQ-017 Pulses SHALL be mutually exclusive; phase and lat SHALL hold their values until the next done.

Reset
REQ-018 rst SHALL asynchronously force IDLE and zero all outputs, counters and zero_run, including in the middle of a burst.
REQ-019 After rst deasserts, the block SHALL ignore dqs_samples until the next rd_start.

Verification
(Parameters PREAMBLE_LOW=2, BURST_WORDS=2, TIMEOUT=16; words are written s0s1s2s3; rd_start at cycle 0, words applied from cycle 1.)
REQ-020 Words 1111, 0000, 1010, 1010 -> done at cycle 5, phase=0, lat=2, no errors.
REQ-021 Words 0000, 0010, 1010, 1000 -> done with phase=2, lat=1.
REQ-022 Words 0000, 1010, 1110 -> err_glitch one cycle after 1110, done never asserts, busy=0 afterwards.
REQ-023 Sixteen words of 0000 -> err_timeout one cycle after the 16th word; words 1111 then 1011 -> err_preamble after 1011.
REQ-024 rd_start pulsed during BURST of scenario REQ-020 -> err_overlap pulse and done still at cycle 5; rst asserted during BURST -> busy=0 and all outputs 0 immediately, and a subsequent clean burst completes normally.
